// File: rtl/serial_add_ctrl_if.sv
// Requester-side bus of the bit-serial adder controller: start/busy/done
// handshake, operands and result. Port sub exists only when the build
// defines SERIAL_ADD_SUB_EN.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB first, one
// bit per clock, to form {cout,sum} = a + b + cin over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a sub input selecting a - b.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [1:0]       fa;
    logic [WIDTH-1:0] res_next;

    // The single shared cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    // Operand B and initial carry as loaded on an accepted start; subtraction
    // is a + ~b + 1, so it only changes what gets loaded.
    always_comb begin
        b_load = bus.b;
        c_load = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            b_load = ~bus.b;
            c_load = 1'b1;
        end
`endif
    end

    assign fa       = full_add(sh_a[0], sh_b[0], carry);
    assign res_next = {fa[0], res_sh[WIDTH-1:1]};

    // Controller FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= b_load;
                        carry  <= c_load;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    res_sh <= res_next;
                    carry  <= fa[1];
                    cnt    <= cnt + CNT_W'(1);
                    // Last bit: publish the result including this bit's sum.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum_r  <= res_next;
                        cout_r <= fa[1];
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: cycle-level reference model built from the
// arithmetic result and latency, compared every cycle, plus literal checks.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result is plain arithmetic, timing is "WIDTH edges busy,
    // then one done cycle, then idle".
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    int           m_left = 0;
    logic [W:0]   m_pend = '0;
    logic         m_sub;

    always_comb begin
        m_sub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        m_sub = bus.sub;
`endif
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_cout, m_sum} <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.start) begin
            m_busy <= 1'b1;
            m_left <= W;
            if (m_sub)
                m_pend <= {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1);
            else
                m_pend <= {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("done", 64'(bus.done), 64'(m_done));
            check("sum",  64'(bus.sum),  64'(m_sum));
            check("cout", 64'(bus.cout), 64'(m_cout));
        end
    end

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= done_cyc;
            done_cyc      <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("note: sub ignored in this build");
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, leaves the caller sampling at that negedge.
    task automatic wait_done(input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n = n + 1;
            if (bus.done === 1'b1) break;
            if (n > 40) begin
                check({name, "_timeout"}, 64'(0), 64'(1));
                break;
            end
        end
    endtask

    initial begin
        int n;
        int base;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sum",  64'(bus.sum),  64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        repeat (3) tick();
        check("idle_busy", 64'(bus.busy), 64'(0));

        // 3 + 5: done on the 9th negedge after the accepting edge
        issue(8'd3, 8'd5, 1'b0, 1'b0);
        check("run_busy", 64'(bus.busy), 64'(1));
        wait_done("add35", n);
        check("latency", 64'(n), 64'(W + 1));
        check("add35_sum",  64'(bus.sum),  64'(8));
        check("add35_cout", 64'(bus.cout), 64'(0));
        tick();
        check("done_fall", 64'(bus.done), 64'(0));

        // 255 + 1 with an ignored start mid-run
        issue(8'd255, 8'd1, 1'b0, 1'b0);
        repeat (3) tick();
        bus.a = 8'd0; bus.b = 8'd0; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("add255", n);
        check("add255_sum",  64'(bus.sum),  64'(0));
        check("add255_cout", 64'(bus.cout), 64'(1));
        repeat (2) tick();
        check("no_queue_busy", 64'(bus.busy), 64'(0));
        issue(8'd0, 8'd0, 1'b1, 1'b0);
        wait_done("cin1", n);
        check("cin1_sum",  64'(bus.sum),  64'(1));
        check("cin1_cout", 64'(bus.cout), 64'(0));
        repeat (2) tick();

        // start held 20 cycles: two operations, 10 cycles apart
        base = done_cnt;
        bus.a = 8'd100; bus.b = 8'd27; bus.cin = 1'b0; bus.start = 1'b1;
        repeat (20) tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("held_dones", 64'(done_cnt - base), 64'(2));
        check("held_spacing", 64'(done_cyc - prev_done_cyc), 64'(W + 2));
        check("held_sum", 64'(bus.sum), 64'(127));

        // reset mid-run abandons the operation
        issue(8'd200, 8'd100, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = done_cnt;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_sum",  64'(bus.sum),  64'(0));
        check("abort_cout", 64'(bus.cout), 64'(0));
        repeat (15) tick();
        check("abort_nodone", 64'(done_cnt - base), 64'(0));
        issue(8'd1, 8'd1, 1'b0, 1'b0);
        wait_done("add11", n);
        check("add11_sum", 64'(bus.sum), 64'(2));
        tick();

        // rst and start together: start not accepted
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        tick();
        check("rst_start_busy", 64'(bus.busy), 64'(0));
        check("rst_start_sum",  64'(bus.sum),  64'(0));

`ifdef SERIAL_ADD_SUB_EN
        issue(8'd5, 8'd3, 1'b0, 1'b1);
        wait_done("sub53", n);
        check("sub53_sum",  64'(bus.sum),  64'(2));
        check("sub53_cout", 64'(bus.cout), 64'(1));
        tick();
        issue(8'd3, 8'd5, 1'b0, 1'b1);
        wait_done("sub35", n);
        check("sub35_sum",  64'(bus.sum),  64'(254));
        check("sub35_cout", 64'(bus.cout), 64'(0));
        tick();
        issue(8'd5, 8'd3, 1'b1, 1'b0);
        wait_done("add53c", n);
        check("add53c_sum", 64'(bus.sum), 64'(9));
        tick();
`endif

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
